tec8_beat_timer: RTL and testbench

//   Beat/phase timing generator that drives the hardwired controller. Produces the W1/W2/W3

---
 rtl/tec8_timing_pkg.sv | 12 +
 rtl/tec8_qd_sync.sv | 32 +++
 rtl/tec8_beat_timer.sv | 129 ++++++++++++
 tb/tb_tec8_beat_timer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/tec8_timing_pkg.sv
// Shared beat/phase encodings and counter sizing for the TEC-8 beat timer.
package tec8_timing_pkg;

  typedef enum logic [1:0] {HALT, W1, W2, W3} beat_t;
  typedef enum logic [1:0] {T1, T2, T3} phase_t;

  // Bits needed to count 0..n-1; a single-clock phase still gets one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tec8_qd_sync.sv
// Synchronizes the asynchronous console start level QD and emits a one-clock
// pulse on each rising edge that follows an observed low level.
module tec8_qd_sync #(
  parameter int QD_SYNC = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic QD,
  output logic pulse
);

  logic [QD_SYNC-1:0] sync_q;
  logic [QD_SYNC-1:0] fill_q;
  logic               prev_q;

  // prev_q resets high and only tracks samples that have crossed the whole
  // chain, so a QD held high through reset must fall before it can start a run.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[QD_SYNC-2:0], QD};
      fill_q <= {fill_q[QD_SYNC-2:0], 1'b1};
      if (fill_q[QD_SYNC-1]) prev_q <= sync_q[QD_SYNC-1];
    end
  end

  assign pulse = fill_q[QD_SYNC-1] & sync_q[QD_SYNC-1] & ~prev_q;

endmodule

// File: rtl/tec8_beat_timer.sv
// W1/W2/W3 beat and T1/T2/T3 sub-phase generator for the hardwired controller.
// Optional single-beat mode with STEP input when TEC8_STEP_EN is defined.
module tec8_beat_timer #(
  parameter int T_CLKS  = 1,
  parameter int QD_SYNC = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic QD,
  input  logic SHORT,
  input  logic LONG,
  input  logic STOP,
`ifdef TEC8_STEP_EN
  input  logic STEP,
`endif
  output logic RUN,
  output logic W1,
  output logic W2,
  output logic W3,
  output logic T1,
  output logic T2,
  output logic T3,
  output logic BEAT_END
);
  import tec8_timing_pkg::*;

  localparam int            CW       = cnt_w(T_CLKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(T_CLKS - 1);

  beat_t         beat, beat_n, follow;
  phase_t        phase, phase_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          qd_pulse;
`ifdef TEC8_STEP_EN
  beat_t         resume, resume_n;
`endif

  tec8_qd_sync #(.QD_SYNC(QD_SYNC)) u_qd_sync (
    .CLK   (CLK),
    .CLR   (CLR),
    .QD    (QD),
    .pulse (qd_pulse)
  );

  always_comb begin
    beat_n  = beat;
    phase_n = phase;
    cnt_n   = cnt;
`ifdef TEC8_STEP_EN
    resume_n = resume;
`endif
    unique case (beat)
      tec8_timing_pkg::W1: follow = SHORT ? tec8_timing_pkg::W1 : tec8_timing_pkg::W2;
      tec8_timing_pkg::W2: follow = LONG ? tec8_timing_pkg::W3 : tec8_timing_pkg::W1;
      default:             follow = tec8_timing_pkg::W1;
    endcase

    if (beat == tec8_timing_pkg::HALT) begin
      if (qd_pulse) begin
`ifdef TEC8_STEP_EN
        beat_n = resume;
`else
        beat_n = tec8_timing_pkg::W1;
`endif
        phase_n = tec8_timing_pkg::T1;
        cnt_n   = '0;
      end
    end else if (cnt != CNT_LAST) begin
      cnt_n = cnt + 1'b1;
    end else begin
      cnt_n = '0;
      unique case (phase)
        tec8_timing_pkg::T1: phase_n = tec8_timing_pkg::T2;
        tec8_timing_pkg::T2: phase_n = tec8_timing_pkg::T3;
        default:             phase_n = tec8_timing_pkg::T1;
      endcase
      // End of beat: the only point where controller requests are honoured.
      if (phase == tec8_timing_pkg::T3) begin
        if (STOP) begin
          beat_n = tec8_timing_pkg::HALT;
`ifdef TEC8_STEP_EN
          resume_n = tec8_timing_pkg::W1;
        end else if (STEP) begin
          beat_n   = tec8_timing_pkg::HALT;
          resume_n = follow;
`endif
        end else begin
          beat_n = follow;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      beat     <= tec8_timing_pkg::HALT;
      phase    <= tec8_timing_pkg::T1;
      cnt      <= '0;
`ifdef TEC8_STEP_EN
      resume   <= tec8_timing_pkg::W1;
`endif
      RUN      <= 1'b0;
      W1       <= 1'b0;
      W2       <= 1'b0;
      W3       <= 1'b0;
      T1       <= 1'b0;
      T2       <= 1'b0;
      T3       <= 1'b0;
      BEAT_END <= 1'b0;
    end else begin
      beat     <= beat_n;
      phase    <= phase_n;
      cnt      <= cnt_n;
`ifdef TEC8_STEP_EN
      resume   <= resume_n;
`endif
      RUN      <= (beat_n != tec8_timing_pkg::HALT);
      W1       <= (beat_n == tec8_timing_pkg::W1);
      W2       <= (beat_n == tec8_timing_pkg::W2);
      W3       <= (beat_n == tec8_timing_pkg::W3);
      T1       <= (beat_n != tec8_timing_pkg::HALT) && (phase_n == tec8_timing_pkg::T1);
      T2       <= (beat_n != tec8_timing_pkg::HALT) && (phase_n == tec8_timing_pkg::T2);
      T3       <= (beat_n != tec8_timing_pkg::HALT) && (phase_n == tec8_timing_pkg::T3);
      BEAT_END <= (beat_n != tec8_timing_pkg::HALT) && (phase_n == tec8_timing_pkg::T3) &&
                  (cnt_n == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_tec8_beat_timer.sv
// Bench for tec8_beat_timer: two instances (T_CLKS=1/QD_SYNC=2 and T_CLKS=3/QD_SYNC=3)
// checked every clock against a beat-position reference model.
module tb_tec8_beat_timer;

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic QD = 1'b0;
  logic SHORT = 1'b0;
  logic LONG = 1'b0;
  logic STOP = 1'b0;
`ifdef TEC8_STEP_EN
  logic STEP = 1'b0;
`endif

  logic run_a, w1_a, w2_a, w3_a, t1_a, t2_a, t3_a, be_a;
  logic run_b, w1_b, w2_b, w3_b, t1_b, t2_b, t3_b, be_b;

  int compared = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  tec8_beat_timer #(.T_CLKS(1), .QD_SYNC(2)) u_dut_a (
    .CLK(CLK), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
`ifdef TEC8_STEP_EN
    .STEP(STEP),
`endif
    .RUN(run_a), .W1(w1_a), .W2(w2_a), .W3(w3_a),
    .T1(t1_a), .T2(t2_a), .T3(t3_a), .BEAT_END(be_a)
  );

  tec8_beat_timer #(.T_CLKS(3), .QD_SYNC(3)) u_dut_b (
    .CLK(CLK), .CLR(CLR), .QD(QD), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
`ifdef TEC8_STEP_EN
    .STEP(STEP),
`endif
    .RUN(run_b), .W1(w1_b), .W2(w2_b), .W3(w3_b),
    .T1(t1_b), .T2(t2_b), .T3(t3_b), .BEAT_END(be_b)
  );

  // Reference model: beat number (0 = halted), clock position inside the beat,
  // beat to start with on the next QD edge, and the sampled QD history.
  int m_beat[2];
  int m_pos[2];
  int m_res[2];
  int s_hist[$];

  function automatic int tc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int qs_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic model_edge();
    int n, qs, last, nxt;
    bit start;
    if (CLR) begin
      s_hist = {};
      s_hist.push_back(1);
      for (int i = 0; i < 2; i++) begin
        m_beat[i] = 0;
        m_pos[i]  = 0;
        m_res[i]  = 1;
      end
      return;
    end
    s_hist.push_back(int'(QD));
    n = s_hist.size() - 1;
    for (int i = 0; i < 2; i++) begin
      qs    = qs_of(i);
      last  = 3 * tc_of(i) - 1;
      start = (n - qs >= 1) && (s_hist[n-qs] == 1) && (s_hist[n-qs-1] == 0);
      if (m_beat[i] == 0) begin
        if (start) begin
          m_beat[i] = m_res[i];
          m_pos[i]  = 0;
        end
      end else if (m_pos[i] < last) begin
        m_pos[i]++;
      end else begin
        m_pos[i] = 0;
        if (m_beat[i] == 1)      nxt = SHORT ? 1 : 2;
        else if (m_beat[i] == 2) nxt = LONG ? 3 : 1;
        else                     nxt = 1;
        if (STOP) begin
          m_beat[i] = 0;
          m_res[i]  = 1;
`ifdef TEC8_STEP_EN
        end else if (STEP) begin
          m_beat[i] = 0;
          m_res[i]  = nxt;
`endif
        end else begin
          m_beat[i] = nxt;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec(input int i);
    int ph;
    if (m_beat[i] == 0) return 8'b0;
    ph = m_pos[i] / tc_of(i);
    return {1'b1, m_beat[i] == 1, m_beat[i] == 2, m_beat[i] == 3,
            ph == 0, ph == 1, ph == 2, m_pos[i] == 3 * tc_of(i) - 1};
  endfunction

  task automatic check(input string tag);
    logic [7:0] oa, ob, ea, eb;
    oa = {run_a, w1_a, w2_a, w3_a, t1_a, t2_a, t3_a, be_a};
    ob = {run_b, w1_b, w2_b, w3_b, t1_b, t2_b, t3_b, be_b};
    ea = exp_vec(0);
    eb = exp_vec(1);
    compared++;
    assert (oa === ea) else begin
      mismatched++;
      $error("FAIL %s/T1clk t=%0t RUN.W1W2W3.T1T2T3.BE observed=%b expected=%b", tag, $time, oa, ea);
    end
    compared++;
    assert (ob === eb) else begin
      mismatched++;
      $error("FAIL %s/T3clk t=%0t RUN.W1W2W3.T1T2T3.BE observed=%b expected=%b", tag, $time, ob, eb);
    end
  endtask

  task automatic tick(input string tag, input int n);
    repeat (n) begin
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      check(tag);
    end
  endtask

  task automatic qd_pulse(input string tag);
    QD = 1'b1;
    tick(tag, 4);
    QD = 1'b0;
    tick(tag, 4);
  endtask

  initial begin
    // Reset held two clocks with QD low.
    tick("reset", 2);
    CLR = 1'b0;
    tick("idle", 6);

    // Start and plain W1,W2 alternation.
    qd_pulse("start");
    tick("w1w2", 24);

    // SHORT held: W1 repeats.
    SHORT = 1'b1;
    tick("short", 24);
    SHORT = 1'b0;

    // LONG held: W1,W2,W3 cycle.
    LONG = 1'b1;
    tick("long", 30);

    // QD edge while running is discarded.
    qd_pulse("qd_running");

    // STOP with LONG: halt after the current beat.
    STOP = 1'b1;
    tick("stop", 12);
    STOP = 1'b0;
    LONG = 1'b0;
    tick("halted", 6);

    // Restart from W1.
    qd_pulse("restart");
    tick("restart_run", 12);

    // Reset mid-run with QD held high through it: no start until QD falls and rises.
    QD = 1'b1;
    tick("pre_clr", 2);
    CLR = 1'b1;
    tick("clr_mid", 2);
    CLR = 1'b0;
    tick("qd_held", 14);
    QD = 1'b0;
    tick("qd_fall", 5);
    QD = 1'b1;
    tick("qd_rise", 12);
    QD = 1'b0;
    tick("run_after", 6);

`ifdef TEC8_STEP_EN
    // Single-beat mode: every QD edge advances one beat in W1,W2,W3 order.
    LONG = 1'b1;
    STEP = 1'b1;
    tick("step_arm", 12);
    for (int k = 0; k < 6; k++) begin
      qd_pulse("step_resume");
      tick("step_beat", 10);
    end
    STEP = 1'b0;
    LONG = 1'b0;
`endif

    // Randomized controller requests, QD activity and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      SHORT = 1'($urandom_range(0, 1));
      LONG  = 1'($urandom_range(0, 1));
      STOP  = ($urandom_range(0, 15) == 0);
`ifdef TEC8_STEP_EN
      STEP  = ($urandom_range(0, 7) == 0);
`endif
      CLR   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) QD = ~QD;
      tick("random", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
